// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction/flag inputs and datapath control outputs of the multicycle controller
//
// Signals:
//   op, funct, rd, cond   instruction register fields (instr[27:26], [25:20], [15:12], [31:28])
//   alu_flags             {N,Z,C,V} produced by the ALU in the current cycle
//   mem_ready             memory completes the current access this cycle
//   pc_write .. bus_fault datapath mux selects, write enables and fault pulse
// Modports:
//   slave   controller side (instruction/flags in, controls out)
//   master  datapath side (instruction/flags out, controls in)
interface multicycle_controller_if;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [2:0] alu_ctl;
    logic       shift;
    logic       carry;
    logic       bus_fault;

    modport slave (
        input  op, funct, rd, cond, alu_flags, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, reg_src, alu_ctl, shift, carry, bus_fault
    );

    modport master (
        output op, funct, rd, cond, alu_flags, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, reg_src, alu_ctl, shift, carry, bus_fault
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle ARM control unit: main FSM, condition logic, ALU decode, memory wait/timeout
//
// Ports:
//   clk          clock
//   reset        synchronous active-high reset
//   bus          multicycle_controller_if.slave (instruction fields, ALU flags, mem_ready in; all controls out)
//   retired_cnt  retired-instruction counter, present only when MC_RETIRE_CNT_EN is defined
// Parameters:
//   MEM_TIMEOUT  consecutive mem_ready=0 cycles tolerated in a wait state before abort (0 = never abort)
//   CNT_W        retired_cnt width (MC_RETIRE_CNT_EN builds only)
// Optional feature macro: MC_RETIRE_CNT_EN
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16
`ifdef MC_RETIRE_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.slave  bus
`ifdef MC_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]        retired_cnt
`endif
);

    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [3:0]      flags;      // {N,Z,C,V}
    logic            cond_ex;
    logic [TO_W-1:0] wait_cnt;

    logic [3:0] cmd;
    logic       s_bit;
    logic       cmd_ok;
    logic [2:0] cmd_alu;
    logic       cmd_shift;
    logic       is_cmp;
    logic       cmd_cv;
    logic       cond_eval;
    logic       waiting;
    logic       timeout;
    logic       mem_done;
    logic       alu_wr;

    assign cmd   = bus.funct[4:1];
    assign s_bit = bus.funct[0];

    // Data-processing command decode.
    always_comb begin
        cmd_ok    = 1'b1;
        cmd_alu   = 3'b000;
        cmd_shift = 1'b0;
        case (cmd)
            4'b0100: cmd_alu = 3'b000;                      // ADD
            4'b0010: cmd_alu = 3'b001;                      // SUB
            4'b1010: cmd_alu = 3'b001;                      // CMP
            4'b0000: cmd_alu = 3'b010;                      // AND
            4'b1100: cmd_alu = 3'b011;                      // ORR
            4'b0101: cmd_alu = 3'b100;                      // ADC
            4'b1101: begin cmd_alu = 3'b000; cmd_shift = 1'b1; end  // MOV
            default: cmd_ok = 1'b0;
        endcase
    end

    assign is_cmp = (cmd == 4'b1010);
    assign cmd_cv = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010) || (cmd == 4'b0101);

    // Condition check against the stored flags.
    always_comb begin
        cond_eval = 1'b0;
        case (bus.cond)
            4'b0000: cond_eval = flags[2];
            4'b0001: cond_eval = ~flags[2];
            4'b0010: cond_eval = flags[1];
            4'b0011: cond_eval = ~flags[1];
            4'b0100: cond_eval = flags[3];
            4'b0101: cond_eval = ~flags[3];
            4'b0110: cond_eval = flags[0];
            4'b0111: cond_eval = ~flags[0];
            4'b1000: cond_eval = flags[1] & ~flags[2];
            4'b1001: cond_eval = ~flags[1] | flags[2];
            4'b1010: cond_eval = (flags[3] == flags[0]);
            4'b1011: cond_eval = (flags[3] != flags[0]);
            4'b1100: cond_eval = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_eval = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    end

    // A cond-failed store leaves MEMWR at once, so it is not a wait state.
    assign waiting  = (state == S_FETCH) || (state == S_MEMRD) || ((state == S_MEMWR) && cond_ex);
    assign timeout  = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == TO_LIM);
    assign mem_done = waiting && bus.mem_ready && !timeout;
    assign alu_wr   = cond_ex && cmd_ok && !is_cmp;

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  next_state = mem_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    2'b01:   next_state = S_MEMADR;
                    2'b10:   next_state = S_BRANCH;
                    2'b00:   next_state = bus.funct[5] ? S_EXECI : S_EXECR;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = bus.funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = timeout ? S_FETCH : (mem_done ? S_MEMWB : S_MEMRD);
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  next_state = (!cond_ex || timeout || mem_done) ? S_FETCH : S_MEMWR;
            S_EXECR:  next_state = S_ALUWB;
            S_EXECI:  next_state = S_ALUWB;
            S_ALUWB:  next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            flags    <= 4'b0000;
            cond_ex  <= 1'b0;
            wait_cnt <= '0;
`ifdef MC_RETIRE_CNT_EN
            retired_cnt <= '0;
`endif
        end else begin
            state <= next_state;

            if (state == S_DECODE) begin
                cond_ex <= cond_eval;
            end

            // Counts only uninterrupted stall cycles; any progress or abort restarts it.
            if ((MEM_TIMEOUT != 0) && waiting && !bus.mem_ready && !timeout) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (((state == S_EXECR) || (state == S_EXECI)) && cond_ex && cmd_ok && (s_bit || is_cmp)) begin
                flags[3:2] <= bus.alu_flags[3:2];
                if (cmd_cv) begin
                    flags[1:0] <= bus.alu_flags[1:0];
                end
            end

`ifdef MC_RETIRE_CNT_EN
            // FETCH->FETCH is a stall or abort, never a retirement.
            if ((next_state == S_FETCH) && (state != S_FETCH) && !timeout) begin
                retired_cnt <= retired_cnt + 1'b1;
            end
`endif
        end
    end

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.adr_src    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.imm_src    = 2'b00;
        bus.reg_src    = 2'b00;
        bus.alu_ctl    = 3'b000;
        bus.shift      = 1'b0;
        bus.carry      = 1'b0;
        bus.bus_fault  = 1'b0;
        if (!reset) begin
            bus.imm_src   = bus.op;
            bus.reg_src   = {bus.op == 2'b01, bus.op == 2'b10};
            bus.carry     = flags[1] & (cmd == 4'b0101);
            bus.bus_fault = timeout;
            case (state)
                S_FETCH: begin
                    bus.alu_src_a  = 1'b1;
                    bus.alu_src_b  = 2'b10;
                    bus.result_src = 2'b10;
                    bus.ir_write   = mem_done;
                    bus.pc_write   = mem_done;
                end
                S_DECODE: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                S_MEMADR: begin
                    bus.alu_src_b = 2'b01;
                    bus.alu_ctl   = bus.funct[3] ? 3'b000 : 3'b001;
                end
                S_MEMRD: begin
                    bus.adr_src = 1'b1;
                end
                S_MEMWB: begin
                    bus.result_src = 2'b01;
                    bus.reg_write  = cond_ex;
                    bus.pc_write   = cond_ex && (bus.rd == 4'd15);
                end
                S_MEMWR: begin
                    bus.adr_src   = 1'b1;
                    bus.mem_write = cond_ex && !timeout;
                end
                S_EXECR, S_EXECI: begin
                    bus.alu_src_b = (state == S_EXECI) ? 2'b01 : 2'b00;
                    bus.alu_ctl   = cmd_alu;
                    bus.shift     = cmd_shift;
                end
                S_ALUWB: begin
                    bus.reg_write = alu_wr;
                    bus.pc_write  = alu_wr && (bus.rd == 4'd15);
                end
                S_BRANCH: begin
                    bus.alu_src_b  = 2'b01;
                    bus.result_src = 2'b10;
                    bus.pc_write   = cond_ex;
                end
                default: begin
                    bus.pc_write = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam int K_FETCH = 0;
    localparam int K_MEMRD = 1;
    localparam int K_MEMWR = 2;

    typedef struct {
        logic          rst;
        logic          mr;
        logic [3:0]    af;
        logic [1:0]    op;
        logic [5:0]    funct;
        logic [3:0]    rd;
        logic [3:0]    cond;
        logic [19:0]   exp;
        logic [CW-1:0] ret;
        bit            chk_ret;
        int            idx;
    } cyc_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    multicycle_controller_if bus ();

`ifdef MC_RETIRE_CNT_EN
    logic [CW-1:0] retired_cnt;
    multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus), .retired_cnt(retired_cnt));
`else
    multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif

    always #5 clk = ~clk;

    cyc_t stim_q[$];
    cyc_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    bit   drv_done = 0;

    // Reference model state: architectural flags and retirement count.
    logic [3:0]    mflags = 4'b0000;
    logic [CW-1:0] mret = '0;
    logic [1:0]    i_op;
    logic [5:0]    i_funct;
    logic [3:0]    i_rd;
    logic [3:0]    i_cond;

    function automatic logic [3:0] r4();
        return 4'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ALU operation for a data-processing cmd; sup=0 for unsupported commands.
    task automatic alu_of(input logic [3:0] cmd, output logic [2:0] ac, output bit sup);
        sup = 1;
        case (cmd)
            4'b0100, 4'b1101: ac = 3'b000;
            4'b0010, 4'b1010: ac = 3'b001;
            4'b0000:          ac = 3'b010;
            4'b1100:          ac = 3'b011;
            4'b0101:          ac = 3'b100;
            default: begin ac = 3'b000; sup = 0; end
        endcase
    endtask

    task automatic emit(input logic mr, input logic [3:0] af, input logic pcw, input logic adrs,
                        input logic mw, input logic irw, input logic rw, input logic [1:0] rs,
                        input logic asa, input logic [1:0] asb, input logic [2:0] ac,
                        input logic sh, input logic bf);
        cyc_t c;
        c.rst = 1'b0; c.mr = mr; c.af = af;
        c.op = i_op; c.funct = i_funct; c.rd = i_rd; c.cond = i_cond;
        c.exp = {pcw, adrs, mw, irw, rw, rs, asa, asb, i_op, i_op == 2'b01, i_op == 2'b10,
                 ac, sh, mflags[1] && (i_funct[4:1] == 4'b0101), bf};
        c.ret = mret; c.chk_ret = 1; c.idx = stim_q.size();
        stim_q.push_back(c);
    endtask

    task automatic emit_reset();
        cyc_t c;
        c.rst = 1'b1; c.mr = rb(); c.af = r4();
        c.op = i_op; c.funct = i_funct; c.rd = i_rd; c.cond = i_cond;
        c.exp = '0; c.ret = '0; c.chk_ret = 0; c.idx = stim_q.size();
        stim_q.push_back(c);
        mflags = 4'b0000;
        mret = '0;
    endtask

    task automatic phase_out(input int kind, input logic mr, input logic ready, input logic bf);
        case (kind)
            K_FETCH: emit(mr, r4(), ready, 1'b0, 1'b0, ready, 1'b0, 2'b10, 1'b1, 2'b10, 3'b000, 1'b0, bf);
            K_MEMRD: emit(mr, r4(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, bf);
            default: emit(mr, r4(), 1'b0, 1'b1, !bf, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, bf);
        endcase
    endtask

    // A memory access: 'waits' stall cycles then ready, aborted once TO stalls have elapsed.
    task automatic wait_phase(input int kind, input int waits, output bit aborted);
        int cnt;
        cnt = 0;
        aborted = 0;
        for (int i = 0; i < waits; i++) begin
            if (cnt == TO) begin
                phase_out(kind, 1'b0, 1'b0, 1'b1);
                aborted = 1;
                return;
            end
            phase_out(kind, 1'b0, 1'b0, 1'b0);
            cnt++;
        end
        if (cnt == TO) begin
            phase_out(kind, 1'b0, 1'b0, 1'b1);
            aborted = 1;
            return;
        end
        phase_out(kind, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic gen_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                             input logic [3:0] cond, input int fw, input int mw,
                             input logic [3:0] exec_af);
        bit ab;
        bit sup;
        logic cex;
        logic wr;
        logic [2:0] ac;
        logic [3:0] cmd;
        i_op = op; i_funct = funct; i_rd = rd; i_cond = cond;
        cmd = funct[4:1];
        do begin
            wait_phase(K_FETCH, fw, ab);
            fw = $urandom_range(0, 2);
        end while (ab);
        emit(rb(), r4(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b000, 1'b0, 1'b0);
        cex = cond_ok(cond, mflags);
        case (op)
            2'b11: mret++;
            2'b10: begin
                emit(rb(), r4(), cex, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0);
                mret++;
            end
            2'b01: begin
                emit(rb(), r4(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01,
                     funct[3] ? 3'b000 : 3'b001, 1'b0, 1'b0);
                if (funct[0]) begin
                    wait_phase(K_MEMRD, mw, ab);
                    if (!ab) begin
                        emit(rb(), r4(), cex && (rd == 4'd15), 1'b0, 1'b0, 1'b0, cex, 2'b01,
                             1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
                        mret++;
                    end
                end else if (!cex) begin
                    emit(rb(), r4(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
                    mret++;
                end else begin
                    wait_phase(K_MEMWR, mw, ab);
                    if (!ab) mret++;
                end
            end
            default: begin
                alu_of(cmd, ac, sup);
                emit(rb(), exec_af, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                     funct[5] ? 2'b01 : 2'b00, ac, cmd == 4'b1101, 1'b0);
                if (cex && sup && (funct[0] || cmd == 4'b1010)) begin
                    mflags[3:2] = exec_af[3:2];
                    if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010 || cmd == 4'b0101)
                        mflags[1:0] = exec_af[1:0];
                end
                wr = cex && sup && (cmd != 4'b1010);
                emit(rb(), r4(), wr && (rd == 4'd15), 1'b0, 1'b0, 1'b0, wr, 2'b00, 1'b0, 2'b00,
                     3'b000, 1'b0, 1'b0);
                mret++;
            end
        endcase
    endtask

    // STR interrupted by reset during its first MEMWR stall cycle.
    task automatic reset_mid_store();
        bit ab;
        i_op = 2'b01; i_funct = 6'b011000; i_rd = 4'd2; i_cond = 4'b1110;
        wait_phase(K_FETCH, 0, ab);
        emit(rb(), r4(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b000, 1'b0, 1'b0);
        emit(rb(), r4(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0);
        phase_out(K_MEMWR, 1'b0, 1'b0, 1'b0);
        emit_reset();
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, idx, act, req);
    endtask

    // Monitor: compares every presented cycle against the scoreboard.
    initial begin
        cyc_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", e.idx,
                      32'({bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                           bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.reg_src,
                           bus.alu_ctl, bus.shift, bus.carry, bus.bus_fault}),
                      32'(e.exp));
`ifdef MC_RETIRE_CNT_EN
                if (e.chk_ret) check("retired_cnt", e.idx, 32'(retired_cnt), 32'(e.ret));
`endif
            end
        end
    end

    // Driver: applies each cycle's inputs and pushes its expected response.
    initial begin
        cyc_t c;
        bus.op = 2'b00; bus.funct = '0; bus.rd = '0; bus.cond = '0;
        bus.alu_flags = '0; bus.mem_ready = 1'b0;
        i_op = 2'b00; i_funct = '0; i_rd = '0; i_cond = '0;

        emit_reset();
        emit_reset();
        gen_instr(2'b00, 6'b001000, 4'd3, 4'b1110, 0, 0, r4());          // ADD
        gen_instr(2'b00, 6'b000101, 4'd4, 4'b1110, 0, 0, 4'b0100);       // SUBS, Z=1
        gen_instr(2'b10, 6'b100000, 4'd0, 4'b0000, 0, 0, r4());          // BEQ taken
        gen_instr(2'b00, 6'b000101, 4'd4, 4'b1110, 0, 0, 4'b0000);       // SUBS, Z=0
        gen_instr(2'b10, 6'b100000, 4'd0, 4'b0000, 0, 0, r4());          // BEQ not taken
        gen_instr(2'b01, 6'b011001, 4'd5, 4'b1110, 0, 3, r4());          // LDR, 3 stalls
        gen_instr(2'b01, 6'b011000, 4'd5, 4'b1110, 0, 10, r4());         // STR timeout
        gen_instr(2'b00, 6'b001001, 4'd6, 4'b1110, 0, 0, 4'b0010);       // ADDS, C=1
        gen_instr(2'b00, 6'b001011, 4'd7, 4'b1110, 0, 0, r4());          // ADC, carry 1
        gen_instr(2'b00, 6'b001001, 4'd6, 4'b1110, 0, 0, 4'b0000);       // ADDS, C=0
        gen_instr(2'b00, 6'b001011, 4'd7, 4'b1110, 0, 0, r4());          // ADC, carry 0
        gen_instr(2'b00, 6'b001000, 4'd3, 4'b1110, 6, 0, r4());          // fetch timeout
        gen_instr(2'b00, 6'b111010, 4'd15, 4'b1110, 1, 0, r4());         // MOV to PC
        gen_instr(2'b00, 6'b011110, 4'd1, 4'b1110, 0, 0, r4());          // unsupported cmd
        reset_mid_store();
        for (int i = 0; i < 150; i++)
            gen_instr(2'($urandom), 6'($urandom), 4'($urandom), 4'($urandom),
                      $urandom_range(0, 5), $urandom_range(0, 6), r4());

        while (stim_q.size() > 0) begin
            c = stim_q.pop_front();
            @(posedge clk);
            #1;
            reset = c.rst;
            bus.mem_ready = c.mr;
            bus.alu_flags = c.af;
            bus.op = c.op;
            bus.funct = c.funct;
            bus.rd = c.rd;
            bus.cond = c.cond;
            exp_q.push_back(c);
        end
        drv_done = 1;
    end

    initial begin
        wait (drv_done);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        n_checks++;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the multicycle ARM core, the next generation of the single-cycle controller. It has the same instruction decode, condition logic and ALU encoding. It sequences each instruction through a main FSM over several cycles, with wait-state memory handshaking and a parametrised memory timeout. It sits between the instruction register / flag outputs of the datapath and all datapath mux selects and write enables.

Parameters:
MEM_TIMEOUT, 16, max consecutive cycles waiting on mem_ready before abort; 0 = wait forever.
CNT_W, 32, retired-instruction counter width (used only with the optional feature).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op  in  2  instr[27:26]
funct  in  6  instr[25:20] (I, cmd[3:0], S/L)
rd  in  4  instr[15:12]
cond  in  4  instr[31:28]
alu_flags  in  4  {N,Z,C,V} from ALU, current cycle
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  PC load enable
adr_src  out  1  0 = PC, 1 = ALUOut drives memory address
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_write  out  1  register file write
result_src  out  2  00 ALUOut, 01 read data, 10 ALUResult
alu_src_a  out  1  0 = reg A, 1 = PC
alu_src_b  out  2  00 reg B, 01 ext imm, 10 constant 4
imm_src  out  2  = op
reg_src  out  2  {op==01, op==10}
alu_ctl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 ADC
shift  out  1  MOV (cmd 1101) uses shifter path
carry  out  1  stored C flag, valid only for ADC
bus_fault  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset: state FETCH, flags register 0000, timeout counter 0, cond_ex 0. All outputs 0 in the reset cycle.
- FETCH: adr_src 0, alu_src_a 1, alu_src_b 10, result_src 10, alu_ctl 000. ir_write and pc_write assert only in the cycle mem_ready=1, then go to DECODE. Otherwise hold in FETCH.
- DECODE: alu_src_a 1, alu_src_b 10 (PC+8 precompute). Register cond_ex from cond and the flags register: EQ 0000, NE 0001, CS 0010, CC 0011, MI 0100, PL 0101, VS 0110, VC 0111, HI 1000, LS 1001, GE 1010, LT 1011, GT 1100, LE 1101, AL 1110; 1111 is false. Next state:
  - op 01 -> MEMADR
  - op 10 -> BRANCH
  - op 00 with funct[5]=1 -> EXECI, with funct[5]=0 -> EXECR
  - op 11 -> FETCH (NOP)
- MEMADR: alu_src_a 0, alu_src_b 01, alu_ctl = funct[3] ? 000 : 001. Go to MEMRD if funct[0], else MEMWR.
- MEMRD: adr_src 1. Wait for mem_ready, then MEMWB.
- MEMWB: result_src 01, reg_write = cond_ex, then FETCH.
- MEMWR: adr_src 1, mem_write = cond_ex, held until mem_ready, then FETCH. If cond_ex=0, go straight to FETCH without a memory access.
- EXECR / EXECI: alu_src_b 00 / 01, alu_ctl from cmd: 0100->000, 0010->001, 1010(CMP)->001, 0000->010, 1100->011, 0101->100, 1101->000 with shift=1. Go to ALUWB.
- ALUWB: result_src 00, reg_write = cond_ex & cmd!=CMP & cmd supported, then FETCH.
- Flags update: on the EXEC->ALUWB edge, only if cond_ex & (S | CMP).
  - N,Z update for all supported cmds.
  - C,V update only for ADD/SUB/CMP/ADC.
- carry = flags-register C & (cmd==0101).
- BRANCH: alu_src_a 0, alu_src_b 01, result_src 10, pc_write = cond_ex, then FETCH.
- rd==15 with reg_write in ALUWB/MEMWB also asserts pc_write.
- Timeout: the counter increments in FETCH/MEMRD/MEMWR while mem_ready=0 and clears on state change. On reaching MEM_TIMEOUT (if nonzero):
  - bus_fault pulses for 1 cycle
  - state -> FETCH
  - no pc_write/ir_write/reg_write/mem_write that cycle; PC not advanced
- mem_ready outside the wait states is ignored.
- Unsupported cmd: no register or flag write.
- Reset mid-instruction: returns to FETCH next cycle and deasserts all strobes.

Optional Feature:
MC_RETIRE_CNT_EN: adds output retired_cnt [CNT_W-1:0], reset 0.
- Increments by 1 on every transition into FETCH except timeout aborts and the reset exit; cond-failed instructions count.
- Wraps at 2^CNT_W.
- Without the macro, the port and counter are absent.

Test Plan:
- ADD reg (op 00, funct 001000, cond 1110), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB; ir_write in cycle 1; alu_ctl 000 in EXECR; reg_write 1 in ALUWB; back in FETCH at cycle 5.
- SUBS then BEQ: SUB funct 000101 with alu_flags 0100 -> Z latched; BRANCH with cond 0000 -> pc_write 1. With alu_flags 0000 latched instead -> pc_write 0.
- LDR (op 01, funct 011001) with mem_ready low 3 cycles in MEMRD -> stays in MEMRD 4 cycles; MEMWB has result_src 01, reg_write 1.
- STR with MEM_TIMEOUT=4 and mem_ready held 0 -> mem_write held 4 cycles; bus_fault pulses once; next state FETCH; no reg_write.
- ADC (funct 001011) after flags C=1 (alu_flags 0010 latched) -> alu_ctl 100, carry 1. With C=0 -> carry 0.
- Assert reset in MEMWR -> next cycle mem_write 0, state FETCH; retired_cnt (MC_RETIRE_CNT_EN) = 0.
